// File: rtl/rsa_pkg.sv
// rsa_pkg: shared definitions for the RSA decryption slice.
//   WIDTH       default operand width for c, d, n and m
//   state_t     encoding of the decryptor control FSM
//   mul_latency cycles the sequential modular multiplier needs per product
//   MUL_LAT     that latency at the default width
package rsa_pkg;

  localparam int WIDTH = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_EVAL  = 3'd2,
    ST_MUL   = 3'd3,
    ST_SHIFT = 3'd4,
    ST_SQR   = 3'd5,
    ST_FIN   = 3'd6
  } state_t;

  // One cycle to load operands, then one cycle per multiplier bit.
  function automatic int mul_latency(input int w);
    return w + 1;
  endfunction

  localparam int MUL_LAT = mul_latency(WIDTH);

endpackage

// File: rtl/rsa_decrypt_core_if.sv
// rsa_decrypt_core_if: start/done operand bus of the RSA decryptor.
//   start, c, d_key, n : request and operands, driven by the master
//   busy, done, err, m : status and plaintext, driven by the core (slave)
interface rsa_decrypt_core_if #(
  parameter int WIDTH = rsa_pkg::WIDTH
);
  logic             start;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d_key;
  logic [WIDTH-1:0] n;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] m;

  modport master (
    output start, c, d_key, n,
    input  busy, done, err, m
  );

  modport slave (
    input  start, c, d_key, n,
    output busy, done, err, m
  );
endinterface

// File: rtl/mod_mul_seq.sv
// mod_mul_seq: interleaved MSB-first modular multiplier, p = a*b mod n.
//   clk, rst : clock, synchronous active-high reset
//   go       : start (or restart) a product; operands latched on this edge
//   a, b, n  : operands, a and b must be below n
//   p        : product, held until the next completion
//   valid    : one-cycle pulse, LAT cycles after go is sampled
module mod_mul_seq
  import rsa_pkg::*;
#(
  parameter int WIDTH = rsa_pkg::WIDTH,
  parameter int LAT   = MUL_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] p,
  output logic             valid
);

  localparam int CNT_W = $clog2(LAT);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(LAT - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH+1:0] acc_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] p_r;
  logic [CNT_W-1:0] cnt_r;
  logic             running_r;
  logic             valid_r;

  logic [WIDTH+1:0] n_ext_s;
  logic [WIDTH+1:0] a_ext_s;
  logic [WIDTH+1:0] dbl_s;
  logic [WIDTH+1:0] red1_s;
  logic [WIDTH+1:0] sum_s;
  logic [WIDTH+1:0] red2_s;

  // One interleaved step: acc = 2*acc mod n, then add a for a set bit of b.
  // acc < n keeps both partial values below 2n, so one subtraction each suffices.
  always_comb begin
    n_ext_s = {2'b00, n_r};
    a_ext_s = {2'b00, a_r};
    dbl_s   = acc_r << 1;
    if (dbl_s >= n_ext_s) begin
      red1_s = dbl_s - n_ext_s;
    end else begin
      red1_s = dbl_s;
    end
    if (b_r[WIDTH-1]) begin
      sum_s = red1_s + a_ext_s;
    end else begin
      sum_s = red1_s;
    end
    if (sum_s >= n_ext_s) begin
      red2_s = sum_s - n_ext_s;
    end else begin
      red2_s = sum_s;
    end
  end

  // Operand load on go, then one multiplier bit per cycle, MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= {(WIDTH+2){1'b0}};
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      n_r       <= {WIDTH{1'b0}};
      p_r       <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      running_r <= 1'b0;
      valid_r   <= 1'b0;
    end else if (go) begin
      acc_r     <= {(WIDTH+2){1'b0}};
      a_r       <= a;
      b_r       <= b;
      n_r       <= n;
      cnt_r     <= {CNT_W{1'b0}};
      running_r <= 1'b1;
      valid_r   <= 1'b0;
    end else if (running_r) begin
      acc_r <= red2_s;
      b_r   <= b_r << 1;
      cnt_r <= cnt_r + CNT_ONE;
      if (cnt_r == LAST_STEP) begin
        running_r <= 1'b0;
        valid_r   <= 1'b1;
        p_r       <= red2_s[WIDTH-1:0];
      end else begin
        valid_r <= 1'b0;
      end
    end else begin
      valid_r <= 1'b0;
    end
  end

  assign p     = p_r;
  assign valid = valid_r;

endmodule

// File: rtl/rsa_decrypt_core.sv
// rsa_decrypt_core: sequential RSA decryptor, m = c^d mod n, using
// right-to-left binary square-and-multiply on a shared sequential multiplier.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of rsa_decrypt_core_if
//              start/c/d_key/n in; busy/done/err/m out (all registered)
module rsa_decrypt_core
  import rsa_pkg::*;
#(
  parameter int WIDTH = rsa_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  rsa_decrypt_core_if.slave    bus
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TWO  = {{(WIDTH-2){1'b0}}, 2'b10};

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] exp_r;
  logic [WIDTH-1:0] base_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] n_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic [WIDTH-1:0] m_r;

  logic [WIDTH-1:0] exp_shift_s;
  logic             err_flag_s;
  logic             mul_go_s;
  logic [WIDTH-1:0] mul_a_s;
  logic [WIDTH-1:0] mul_b_s;
  logic [WIDTH-1:0] mul_p_s;
  logic             mul_valid_s;

  mod_mul_seq #(
    .WIDTH (WIDTH),
    .LAT   (mul_latency(WIDTH))
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .go    (mul_go_s),
    .a     (mul_a_s),
    .b     (mul_b_s),
    .n     (n_r),
    .p     (mul_p_s),
    .valid (mul_valid_s)
  );

  // Next-state logic and multiplier launch; MUL/SQR leave on the multiplier's valid.
  always_comb begin
    state_next_s = state_r;
    err_flag_s   = 1'b0;
    mul_go_s     = 1'b0;
    mul_a_s      = result_r;
    mul_b_s      = base_r;
    exp_shift_s  = exp_r >> 1;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        // base_r still holds the latched ciphertext here.
        if ((n_r < TWO) || (base_r >= n_r)) begin
          state_next_s = ST_FIN;
          err_flag_s   = 1'b1;
        end else if (exp_r == ZERO) begin
          state_next_s = ST_FIN;
        end else begin
          state_next_s = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (exp_r[0]) begin
          mul_go_s     = 1'b1;
          mul_a_s      = result_r;
          mul_b_s      = base_r;
          state_next_s = ST_MUL;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_MUL: begin
        if (mul_valid_s) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_MUL;
        end
      end
      ST_SHIFT: begin
        // No squaring after the last exponent bit.
        if (exp_shift_s == ZERO) begin
          state_next_s = ST_FIN;
        end else begin
          mul_go_s     = 1'b1;
          mul_a_s      = base_r;
          mul_b_s      = base_r;
          state_next_s = ST_SQR;
        end
      end
      ST_SQR: begin
        if (mul_valid_s) begin
          state_next_s = ST_EVAL;
        end else begin
          state_next_s = ST_SQR;
        end
      end
      ST_FIN: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      exp_r    <= ZERO;
      base_r   <= ZERO;
      result_r <= ZERO;
      n_r      <= ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      m_r      <= ZERO;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            exp_r    <= bus.d_key;
            base_r   <= bus.c;
            n_r      <= bus.n;
            result_r <= ONE;
          end
        end
        ST_MUL: begin
          if (mul_valid_s) begin
            result_r <= mul_p_s;
          end
        end
        ST_SHIFT: begin
          exp_r <= exp_shift_s;
        end
        ST_SQR: begin
          if (mul_valid_s) begin
            base_r <= mul_p_s;
          end
        end
        default: begin
        end
      endcase
      // Outputs are computed one edge early so they line up with the FIN state.
      busy_r <= (state_next_s != ST_IDLE);
      done_r <= (state_next_s == ST_FIN);
      if (state_next_s == ST_FIN) begin
        err_r <= err_flag_s;
        m_r   <= err_flag_s ? ZERO : result_r;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;
  assign bus.m    = m_r;

endmodule
